// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: parses LOAD/SHOW command frames from an SPI byte stream,
// writes {G,R,B} pixel words to an external RAM and triggers the NeoPixel driver.
module spi_frame_ctrl #(
  parameter int NUM_PIX = 64,
  parameter int ADDR_W  = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ready_i,
  input  logic              frame_act_i,
  input  logic              drv_busy_i,
  output logic              pix_we_o,
  output logic [ADDR_W-1:0] pix_addr_o,
  output logic [23:0]       pix_data_o,
  output logic              show_o,
  output logic              busy_o,
  output logic [7:0]        err_cnt_o,
  output logic [2:0]        dbg_state_o
);

  // Handshake: rx_ready_i qualifies rx_data_i for exactly one cycle and has no
  // back-pressure; pix_we_o and show_o are one-cycle strobes with no acknowledge,
  // and pix_addr_o/pix_data_o hold their value until the next write.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CMD       = 3'd1,
    S_LEN       = 3'd2,
    S_PIX       = 3'd3,
    S_SHOW_WAIT = 3'd4,
    S_DISCARD   = 3'd5
  } state_t;

  localparam logic [8:0] MAX_N = 9'(NUM_PIX);

  state_t              state_q, state_d;
  logic                act_q;
  logic [7:0]          len_q, len_d;
  logic [7:0]          idx_q, idx_d;
  logic [1:0]          phase_q, phase_d;
  logic [15:0]         asm_q, asm_d;
  logic                we_d, show_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [23:0]         data_d;
  logic [7:0]          err_d;
  logic                err_inc;
  logic                act_rise, act_fall;

  assign act_rise    = frame_act_i & ~act_q;
  assign act_fall    = ~frame_act_i & act_q;
  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = pix_addr_o;
    data_d  = pix_data_o;
    show_d  = 1'b0;
    err_inc = 1'b0;
    err_d   = err_cnt_o;

    case (state_q)
      S_IDLE: if (act_rise) state_d = S_CMD;
      S_CMD: begin
        if (rx_ready_i) begin
          if (rx_data_i == 8'h01)      state_d = S_LEN;
          else if (rx_data_i == 8'h02) state_d = S_SHOW_WAIT;
          else begin
            state_d = S_DISCARD;
            err_inc = 1'b1;
          end
        end
      end
      S_LEN: begin
        if (rx_ready_i) begin
          if (rx_data_i != 8'd0 && {1'b0, rx_data_i} <= MAX_N) begin
            len_d   = rx_data_i;
            idx_d   = 8'd0;
            phase_d = 2'd0;
            state_d = S_PIX;
          end else begin
            state_d = S_DISCARD;
            err_inc = 1'b1;
          end
        end
      end
      S_PIX: begin
        if (rx_ready_i) begin
          asm_d = {asm_q[7:0], rx_data_i};
          if (phase_q == 2'd2) begin
            phase_d = 2'd0;
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_W-1:0];
            data_d  = {asm_q, rx_data_i};
            idx_d   = idx_q + 8'd1;
            // Leaving PIX on the final write lets it win over a same-cycle abort.
            if (idx_q == len_q - 8'd1) state_d = S_SHOW_WAIT;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      S_SHOW_WAIT: begin
        if (!drv_busy_i) begin
          show_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DISCARD: if (!frame_act_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort is applied after the byte of this cycle has been processed.
    if (act_fall && (state_d == S_CMD || state_d == S_LEN || state_d == S_PIX)) begin
      state_d = S_IDLE;
      err_inc = 1'b1;
    end

    if (err_inc && err_cnt_o != 8'hFF) err_d = err_cnt_o + 8'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      act_q      <= 1'b0;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      phase_q    <= 2'd0;
      asm_q      <= 16'd0;
      pix_we_o   <= 1'b0;
      pix_addr_o <= '0;
      pix_data_o <= 24'd0;
      show_o     <= 1'b0;
      err_cnt_o  <= 8'd0;
    end else begin
      state_q    <= state_d;
      act_q      <= frame_act_i;
      len_q      <= len_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      asm_q      <= asm_d;
      pix_we_o   <= we_d;
      pix_addr_o <= addr_d;
      pix_data_o <= data_d;
      show_o     <= show_d;
      err_cnt_o  <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: directed corner sequences, a frame vector table and
// randomized frames scored against a byte-list model of the protocol.
module tb_spi_frame_ctrl;

  localparam int NP = 64;
  localparam int AW = 6;
  localparam int W  = AW + 24;
  localparam int NV = 9;

  logic          clk;
  logic          reset_i;
  logic [7:0]    rx_data_i;
  logic          rx_ready_i;
  logic          frame_act_i;
  logic          drv_busy_i;
  logic          pix_we_o;
  logic [AW-1:0] pix_addr_o;
  logic [23:0]   pix_data_o;
  logic          show_o;
  logic          busy_o;
  logic [7:0]    err_cnt_o;
  logic [2:0]    dbg_state_o;

  spi_frame_ctrl #(.NUM_PIX(NP), .ADDR_W(AW)) dut (
    .clk_i(clk), .reset_i(reset_i), .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i),
    .frame_act_i(frame_act_i), .drv_busy_i(drv_busy_i), .pix_we_o(pix_we_o),
    .pix_addr_o(pix_addr_o), .pix_data_o(pix_data_o), .show_o(show_o),
    .busy_o(busy_o), .err_cnt_o(err_cnt_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   fb[$];
  int total = 0;
  int bad   = 0;
  int show_cnt = 0;
  int m_err = 0;
  int m_show = 0;

  typedef struct {
    logic [7:0] cmd;
    bit         has_len;
    logic [7:0] n;
    int         pix_sent;
    int         exp_wr;
    int         exp_show;
    int         exp_err;
  } vec_t;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  function automatic logic [7:0] pat(input int v, input int k);
    return 8'(v * 37 + k * 11 + 5);
  endfunction

  // Monitor: every write must match the head of the expected queue.
  initial begin
    logic         show_prev;
    logic [W-1:0] e;
    show_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pix_we_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%06h, required no write",
                   pix_addr_o, pix_data_o);
        end else begin
          e = exp_q.pop_front();
          check("write", 32'({pix_addr_o, pix_data_o}), 32'(e));
        end
      end
      if (show_o) begin
        show_cnt++;
        check("show_width", 32'(show_prev), 32'd0);
      end
      show_prev = show_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic frame_begin();
    frame_act_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
  endtask

  task automatic send_last(input logic [7:0] b);
    rx_data_i   = b;
    rx_ready_i  = 1'b1;
    frame_act_i = 1'b0;
    @(negedge clk);
    rx_ready_i  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    frame_act_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic hard_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  // Protocol model over the whole byte list of one frame (frame ends after fb).
  task automatic model_frame();
    int nb, n, k, lim;
    nb = fb.size();
    if (nb == 0) m_err++;
    else if (fb[0] == 8'h02) m_show++;
    else if (fb[0] != 8'h01) m_err++;
    else if (nb < 2) m_err++;
    else begin
      n = int'(fb[1]);
      if (n == 0 || n > NP) m_err++;
      else begin
        k = (nb - 2) / 3;
        lim = (k < n) ? k : n;
        for (int i = 0; i < lim; i++)
          exp_q.push_back({AW'(i), fb[2+3*i], fb[3+3*i], fb[4+3*i]});
        if (k >= n) m_show++;
        else m_err++;
      end
    end
    if (m_err > 255) m_err = 255;
  endtask

  // ---------------- test ----------------
  initial begin
    int err0, sh0, cmd, n, nb, full;

    vecs[0] = '{8'h01, 1'b1, 8'd2,  2,  2,  1, 0};
    vecs[1] = '{8'h07, 1'b0, 8'd0,  0,  0,  0, 1};
    vecs[2] = '{8'h01, 1'b1, 8'd0,  0,  0,  0, 1};
    vecs[3] = '{8'h01, 1'b1, 8'd65, 0,  0,  0, 1};
    vecs[4] = '{8'h01, 1'b1, 8'd64, 64, 64, 1, 0};
    vecs[5] = '{8'h01, 1'b1, 8'd3,  1,  1,  0, 1};
    vecs[6] = '{8'h02, 1'b0, 8'd0,  0,  0,  1, 0};
    vecs[7] = '{8'h01, 1'b1, 8'd1,  2,  1,  1, 0};
    vecs[8] = '{8'h01, 1'b0, 8'd0,  0,  0,  0, 1};

    reset_i = 1'b1; rx_data_i = 8'd0; rx_ready_i = 1'b0;
    frame_act_i = 1'b0; drv_busy_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we",   32'(pix_we_o),   32'd0);
    check("rst_addr", 32'(pix_addr_o), 32'd0);
    check("rst_data", 32'(pix_data_o), 32'd0);
    check("rst_show", 32'(show_o),     32'd0);
    check("rst_busy", 32'(busy_o),     32'd0);
    check("rst_err",  32'(err_cnt_o),  32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    // LOAD of 2 pixels with exact write latency
    sh0 = show_cnt;
    exp_q.push_back({AW'(0), 24'h112233});
    exp_q.push_back({AW'(1), 24'h445566});
    frame_begin();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    check("load_we_early", 32'(pix_we_o), 32'd0);
    send_byte(8'h33);
    check("load_we0",   32'(pix_we_o),   32'd1);
    check("load_addr0", 32'(pix_addr_o), 32'd0);
    check("load_data0", 32'(pix_data_o), 32'h112233);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    check("load_we1",   32'(pix_we_o),   32'd1);
    check("load_addr1", 32'(pix_addr_o), 32'd1);
    check("load_data1", 32'(pix_data_o), 32'h445566);
    @(negedge clk);
    check("load_show", 32'(show_o), 32'd1);
    frame_end();
    check("load_show_cnt", 32'(show_cnt - sh0), 32'd1);
    check("load_err",  32'(err_cnt_o), 32'd0);
    check("load_busy", 32'(busy_o),    32'd0);

    // SHOW with driver busy for 50 cycles, frame dropped meanwhile
    sh0 = show_cnt;
    drv_busy_i = 1'b1;
    frame_begin();
    send_byte(8'h02);
    repeat (10) @(negedge clk);
    frame_act_i = 1'b0;
    repeat (40) @(negedge clk);
    check("busy_hold_show", 32'(show_cnt - sh0), 32'd0);
    check("busy_hold_busy", 32'(busy_o), 32'd1);
    drv_busy_i = 1'b0;
    @(negedge clk);
    check("busy_release_show", 32'(show_o), 32'd1);
    @(negedge clk);
    check("busy_release_low",  32'(show_o), 32'd0);
    check("busy_release_idle", 32'(busy_o), 32'd0);
    check("busy_show_cnt", 32'(show_cnt - sh0), 32'd1);
    check("busy_err", 32'(err_cnt_o), 32'd0);

    // bad command, bad length
    frame_begin(); send_byte(8'h07); frame_end();
    check("badcmd_err", 32'(err_cnt_o), 32'd1);
    frame_begin(); send_byte(8'h01); send_byte(8'h00); frame_end();
    check("badlen_err", 32'(err_cnt_o), 32'd2);
    check("bad_nowrite", 32'(exp_q.size()), 32'd0);

    // abort after one of three pixels
    sh0 = show_cnt;
    exp_q.push_back({AW'(0), 24'hAABBCC});
    frame_begin();
    send_byte(8'h01); send_byte(8'h03); send_byte(8'hAA);
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    frame_end();
    check("abort_err",  32'(err_cnt_o), 32'd3);
    check("abort_show", 32'(show_cnt - sh0), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_drain", 32'(exp_q.size()), 32'd0);

    // final write and frame fall in the same cycle: write wins, no error
    sh0 = show_cnt;
    exp_q.push_back({AW'(0), 24'hA1B2C3});
    frame_begin();
    send_byte(8'h01); send_byte(8'h01); send_byte(8'hA1); send_byte(8'hB2);
    send_last(8'hC3);
    check("lastfall_err",  32'(err_cnt_o), 32'd3);
    check("lastfall_show", 32'(show_cnt - sh0), 32'd1);
    check("lastfall_drain", 32'(exp_q.size()), 32'd0);

    // command byte and frame fall in the same cycle: byte first, then abort
    frame_begin();
    send_last(8'h01);
    check("cmdfall_err",  32'(err_cnt_o), 32'd4);
    check("cmdfall_busy", 32'(busy_o), 32'd0);

    // vector table
    for (int v = 0; v < NV; v++) begin
      err0 = int'(err_cnt_o);
      sh0  = show_cnt;
      for (int i = 0; i < vecs[v].exp_wr; i++)
        exp_q.push_back({AW'(i), pat(v, 3*i), pat(v, 3*i+1), pat(v, 3*i+2)});
      frame_begin();
      send_byte(vecs[v].cmd);
      if (vecs[v].has_len) send_byte(vecs[v].n);
      for (int i = 0; i < 3 * vecs[v].pix_sent; i++) send_byte(pat(v, i));
      frame_end();
      check("vec_err",   32'(err_cnt_o), 32'(err0 + vecs[v].exp_err));
      check("vec_show",  32'(show_cnt - sh0), 32'(vecs[v].exp_show));
      check("vec_drain", 32'(exp_q.size()), 32'd0);
      check("vec_busy",  32'(busy_o), 32'd0);
    end

    // saturation
    for (int i = 0; i < 300; i++) begin
      frame_begin(); send_byte(8'hEE); frame_end();
    end
    check("sat_err", 32'(err_cnt_o), 32'd255);

    // reset in the middle of PIX
    sh0 = show_cnt;
    frame_begin();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
    #2 reset_i = 1'b1;
    #1;
    check("midrst_we",   32'(pix_we_o),   32'd0);
    check("midrst_addr", 32'(pix_addr_o), 32'd0);
    check("midrst_data", 32'(pix_data_o), 32'd0);
    check("midrst_show", 32'(show_o),     32'd0);
    check("midrst_busy", 32'(busy_o),     32'd0);
    check("midrst_err",  32'(err_cnt_o),  32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
    send_byte(8'hFF); send_byte(8'h11); send_byte(8'h22);
    frame_end();
    check("midrst_trail_show", 32'(show_cnt - sh0), 32'd0);
    check("midrst_trail_drain", 32'(exp_q.size()), 32'd0);

    // randomized frames against the model
    hard_reset();
    m_err = 0;
    m_show = 0;
    sh0 = show_cnt;
    for (int f = 0; f < 60; f++) begin
      fb.delete();
      cmd = $urandom_range(0, 9);
      if (cmd <= 5)      cmd = 1;
      else if (cmd <= 7) cmd = 2;
      else               cmd = $urandom_range(0, 255);
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(63, 66) : $urandom_range(0, 5);
      full = 2 + 3 * n;
      if ($urandom_range(0, 2) != 0) nb = full + $urandom_range(0, 2);
      else                           nb = $urandom_range(0, full + 2);
      for (int k = 0; k < nb; k++) begin
        if (k == 0)      fb.push_back(8'(cmd));
        else if (k == 1) fb.push_back(8'(n));
        else             fb.push_back(8'($urandom_range(0, 255)));
      end
      model_frame();
      frame_begin();
      for (int k = 0; k < nb; k++) begin
        send_byte(fb[k]);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      frame_end();
      check("rand_err",   32'(err_cnt_o), 32'(m_err));
      check("rand_show",  32'(show_cnt - sh0), 32'(m_show));
      check("rand_drain", 32'(exp_q.size()), 32'd0);
    end

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_PIX, default 64, meaning the number of pixels in the external pixel RAM (range 1..256).
REQ-002 SHALL have parameter ADDR_W, default 6, meaning the pixel RAM address width (2^ADDR_W >= NUM_PIX).
REQ-003 SHALL have port clk_i, input, 1, the single system clock.
REQ-004 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx_data_i, input, 8, the received SPI byte; valid when rx_ready_i is high.
REQ-006 SHALL have port rx_ready_i, input, 1, a one-cycle strobe per received byte.
REQ-007 SHALL have port frame_act_i, input, 1, high while SPI slave select is active (already synchronized).
REQ-008 SHALL have port drv_busy_i, input, 1, high while the NeoPixel driver is shifting out.
REQ-009 SHALL have port pix_we_o, output, 1, a one-cycle pixel RAM write strobe.
REQ-010 SHALL have port pix_addr_o, output, ADDR_W, the pixel RAM write address.
REQ-011 SHALL have port pix_data_o, output, 24, the pixel word {G,R,B}.
REQ-012 SHALL have port show_o, output, 1, a one-cycle strobe that starts the driver.
REQ-013 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port err_cnt_o, output, 8, a saturating protocol-error count.

Function
REQ-015 SHALL define the frame protocol as: byte0 = CMD, 0x01 LOAD or 0x02 SHOW; for LOAD, byte1 = N (pixel count), followed by 3*N bytes in G,R,B order per pixel, starting at address 0.
REQ-016 SHALL implement the states IDLE, CMD, LEN, PIX, SHOW_WAIT and DISCARD.
REQ-017 SHALL move IDLE->CMD on a rising edge of frame_act_i, detected with a registered copy of frame_act_i.
REQ-018 SHALL, in CMD on rx_ready_i, act on the byte as follows: 0x01->LEN; 0x02->SHOW_WAIT; any other value->DISCARD with err_cnt_o+1.
REQ-019 SHALL, in LEN on rx_ready_i, act on N as follows: N in 1..NUM_PIX latches N, clears the pixel index and byte phase, and goes to PIX; N=0 or N>NUM_PIX goes to DISCARD with err_cnt_o+1.
REQ-020 SHALL, in PIX, shift bytes into a 24-bit assembly register with a byte phase counter 0..2.
REQ-021 SHALL, on the phase-2 byte, assert pix_we_o in the following cycle, with pix_addr_o = pixel index and pix_data_o = {G,R,B}.
REQ-022 SHALL hold pix_addr_o and pix_data_o stable while pix_we_o is high; pix_we_o latency SHALL be 1 cycle after the third rx_ready_i.
REQ-023 SHALL increment the pixel index after each write and go to SHOW_WAIT after the write of pixel N-1.
REQ-024 SHALL, in SHOW_WAIT, pulse show_o for exactly one cycle on the first cycle with drv_busy_i low, then go to IDLE.
REQ-025 SHALL, if drv_busy_i is high, hold in SHOW_WAIT with no timeout, independent of frame_act_i.
REQ-026 SHALL, in DISCARD, ignore all bytes and return to IDLE when frame_act_i is low.
REQ-027 SHALL, on frame_act_i falling in CMD, LEN or PIX (frame abort), go to IDLE with err_cnt_o+1 and issue no show_o; pixels already written SHALL remain written.
REQ-028 SHALL, on frame_act_i falling while PIX is completing its final write, complete the write and enter SHOW_WAIT with no error (write has priority over abort).
REQ-029 SHALL, in PIX, ignore bytes received after the final pixel and before frame end; a subsequent frame_act_i fall SHALL NOT count as an error.
REQ-030 SHALL treat frame_act_i rising while not in IDLE as no new frame; a new frame SHALL be recognized only from IDLE.
REQ-031 SHALL saturate err_cnt_o at 255, with no wrap-around.
REQ-032 SHALL, if rx_ready_i and a frame_act_i fall occur in the same cycle, process the byte first and then apply the abort rule.

Reset
REQ-033 SHALL, on reset_i high, asynchronously force state=IDLE, pix_we_o=0, pix_addr_o=0, pix_data_o=0, show_o=0, busy_o=0, err_cnt_o=0, and clear the pixel index, byte phase and frame_act_i history.
REQ-034 SHALL, on reset asserted mid-frame, produce no pix_we_o or show_o until a new frame starts from IDLE after release.

Verification
REQ-035 SHALL verify a LOAD of 2 pixels: bytes 01,02,11,22,33,44,55,66 -> writes addr0=0x112233 and addr1=0x445566, each one cycle after the 3rd byte; drv_busy_i=0 -> one show_o pulse; err_cnt_o=0.
REQ-036 SHALL verify a SHOW with the driver busy: byte 02 with drv_busy_i=1 for 50 cycles -> show_o stays 0, then pulses once in the first cycle after drv_busy_i falls.
REQ-037 SHALL verify a bad command and a bad length: bytes 07 -> DISCARD, err_cnt_o=1; bytes 01,00 -> err_cnt_o=2; no pix_we_o in either case.
REQ-038 SHALL verify an abort: bytes 01,03,AA,BB,CC,DD then frame_act_i low -> one write (addr0=0xAABBCC), no show_o, err_cnt_o+1, busy_o=0.
REQ-039 SHALL verify saturation: 300 bad-command frames -> err_cnt_o=255.
REQ-040 SHALL verify reset mid-PIX: after byte 4 of a LOAD, pulse reset_i -> all outputs return to their REQ-033 values immediately, and trailing bytes cause no writes.
